// File: rtl/cpu_latent_wb_arbiter.sv
// rtl/cpu_latent_wb_arbiter.sv - latent result writeback arbiter for the COM-stage register-file port
// Latent results park in per-requester slots and drain round-robin through idle write-port cycles.
module cpu_latent_wb_arbiter #(
  parameter int NREQ         = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_dest,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [4:0]           p5_dest,
  output logic                 wb_valid,
  output logic [4:0]           wb_dest,
  output logic [31:0]          wb_data,
  output logic                 sb_clear,
  output logic [4:0]           sb_clear_dest,
  output logic                 wb_stall
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(STARVE_LIMIT + 1);

  logic [NREQ-1:0] full_q, full_d;
  logic [4:0]      dest_q [NREQ];
  logic [4:0]      dest_d [NREQ];
  logic [31:0]     data_q [NREQ];
  logic [31:0]     data_d [NREQ];
  logic [RRW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_dest_q, wb_dest_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            wb_stall_q, wb_stall_d;

  logic            port_free;
  logic            any_full;
  logic            blocked;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [RRW-1:0]  grant_idx;

  // A stall cycle guarantees no fixed-latency write, so the port is ours regardless of p5_dest.
  always_comb begin
    int slot;
    slot      = 0;
    port_free = (p5_dest == 5'd0) || wb_stall_q;
    any_full  = |full_q;
    blocked   = any_full && !port_free;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (port_free) begin
      for (int k = 0; k < NREQ; k++) begin
        slot = int'(rr_q) + k;
        if (slot >= NREQ) begin
          slot = slot - NREQ;
        end
        if (!grant_any && full_q[slot]) begin
          grant_any   = 1'b1;
          grant_idx   = RRW'(slot);
          grant[slot] = 1'b1;
        end
      end
    end
  end

  // Slot fill only becomes visible next cycle, so a slot is never granted while being filled.
  always_comb begin
    logic store;
    store  = 1'b0;
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !full_q[i] || grant[i];
      store        = req_valid[i] && req_ready[i] && (req_dest[i*5 +: 5] != 5'd0);
      if (store) begin
        full_d[i] = 1'b1;
        dest_d[i] = req_dest[i*5 +: 5];
        data_d[i] = req_data[i*32 +: 32];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    int nxt;
    nxt          = int'(grant_idx) + 1;
    rr_d         = rr_q;
    starve_cnt_d = starve_cnt_q;
    wb_stall_d   = wb_stall_q;
    wb_valid_d   = grant_any;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    if (grant_any) begin
      if (nxt >= NREQ) begin
        nxt = 0;
      end
      rr_d      = RRW'(nxt);
      wb_dest_d = dest_q[grant_idx];
      wb_data_d = data_q[grant_idx];
    end
    if (grant_any || !any_full) begin
      starve_cnt_d = '0;
    end else if (blocked) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    if (grant_any) begin
      wb_stall_d = 1'b0;
    end else if (blocked && (starve_cnt_q == CW'(STARVE_LIMIT - 1))) begin
      wb_stall_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q       <= '0;
      rr_q         <= '0;
      starve_cnt_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_dest_q    <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_stall_q   <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        dest_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      full_q       <= full_d;
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
      wb_stall_q   <= wb_stall_d;
      for (int i = 0; i < NREQ; i++) begin
        dest_q[i] <= dest_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_dest       = wb_dest_q;
  assign wb_data       = wb_data_q;
  assign sb_clear      = wb_valid_q;
  assign sb_clear_dest = wb_dest_q;
  assign wb_stall      = wb_stall_q;

endmodule

// File: tb/tb_cpu_latent_wb_arbiter.sv
// tb/tb_cpu_latent_wb_arbiter.sv - directed bench with a per-cycle reference model for cpu_latent_wb_arbiter
// Model tracks pending results per requester and the run of blocked cycles.
module tb_cpu_latent_wb_arbiter;

  localparam int NREQ  = 3;
  localparam int LIMIT = 8;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_dest;
  logic [NREQ*32-1:0] req_data;
  logic [4:0]        p5_dest;
  logic              wb_valid;
  logic [4:0]        wb_dest;
  logic [31:0]       wb_data;
  logic              sb_clear;
  logic [4:0]        sb_clear_dest;
  logic              wb_stall;

  int checks = 0;
  int errors = 0;

  cpu_latent_wb_arbiter #(.NREQ(NREQ), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .p5_dest(p5_dest),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .sb_clear(sb_clear), .sb_clear_dest(sb_clear_dest),
    .wb_stall(wb_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending result per requester, a round-robin start point,
  // and a count of consecutive cycles a pending result was shut out of the port.
  bit          m_active = 1'b0;
  bit          m_pend [NREQ];
  logic [4:0]  m_dest [NREQ];
  logic [31:0] m_data [NREQ];
  int          m_rr;
  int          m_wait;
  bit          m_stall;
  bit          e_wb_valid;
  logic [4:0]  e_wb_dest;
  logic [31:0] e_wb_data;

  function automatic int model_pick(input logic [4:0] p5);
    int pick;
    pick = -1;
    if (p5 == 5'd0 || m_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        if (pick < 0 && m_pend[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
      end
    end
    return pick;
  endfunction

  always @(posedge clock) begin
    int  pick;
    bit  anyp;
    bit  shut_out;
    if (reset) begin
      m_active   = 1'b1;
      m_rr       = 0;
      m_wait     = 0;
      m_stall    = 1'b0;
      e_wb_valid = 1'b0;
      e_wb_dest  = 5'd0;
      e_wb_data  = 32'd0;
      for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
    end else if (m_active) begin
      pick = model_pick(p5_dest);
      anyp = 1'b0;
      for (int i = 0; i < NREQ; i++) anyp = anyp | m_pend[i];
      shut_out = anyp && !(p5_dest == 5'd0 || m_stall);
      e_wb_valid = (pick >= 0);
      if (pick >= 0) begin
        e_wb_dest    = m_dest[pick];
        e_wb_data    = m_data[pick];
        m_pend[pick] = 1'b0;
        m_rr         = (pick + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !m_pend[i] && req_dest[i*5 +: 5] != 5'd0) begin
          m_pend[i] = 1'b1;
          m_dest[i] = req_dest[i*5 +: 5];
          m_data[i] = req_data[i*32 +: 32];
        end
      end
      if (pick >= 0) begin
        m_wait  = 0;
        m_stall = 1'b0;
      end else if (!anyp) begin
        m_wait = 0;
      end else if (shut_out) begin
        m_wait = m_wait + 1;
        if (m_wait == LIMIT) m_stall = 1'b1;
      end
    end
  end

  always begin
    logic [NREQ-1:0] er;
    int pick;
    @(negedge clock);
    #4;
    if (m_active) begin
      pick = model_pick(p5_dest);
      for (int i = 0; i < NREQ; i++) er[i] = !m_pend[i] || (pick == i);
      chk("m_req_ready", req_ready, er);
      chk("m_wb_valid", wb_valid, e_wb_valid);
      chk("m_sb_clear", sb_clear, e_wb_valid);
      chk("m_wb_stall", wb_stall, m_stall);
      chk("m_wb_dest", wb_dest, e_wb_dest);
      chk("m_wb_data", wb_data, e_wb_data);
      chk("m_sb_clear_dest", sb_clear_dest, e_wb_dest);
    end
  end

  task automatic set_req(input int i, input bit v, input logic [4:0] d, input logic [31:0] x);
    req_valid[i]       = v;
    req_dest[i*5 +: 5] = d;
    req_data[i*32 +: 32] = x;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    p5_dest   = 5'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_dest  = '0;
    req_data  = '0;
    p5_dest   = 5'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);

    // single result through requester 1
    set_req(1, 1'b1, 5'd5, 32'h1234);
    @(negedge clock);
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    chk("t1_valid", wb_valid, 1);
    chk("t1_dest", wb_dest, 5);
    chk("t1_data", wb_data, 32'h1234);
    chk("t1_sbclr", sb_clear_dest, 5);
    @(negedge clock);
    chk("t1_idle", wb_valid, 0);
    chk("t1_hold_dest", wb_dest, 5);

    // three full slots drain 0,1,2 with refills of 0 and 1 during their grants
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    p5_dest = 5'd3;
    @(negedge clock);
    p5_dest = 5'd0;
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    set_req(0, 1'b1, 5'd10, 32'hAA);
    @(negedge clock);
    chk("t2_g0_dest", wb_dest, 1);
    chk("t2_g0_data", wb_data, 32'h11);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd11, 32'hBB);
    @(negedge clock);
    chk("t2_g1_dest", wb_dest, 2);
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    chk("t2_g2_dest", wb_dest, 3);
    @(negedge clock);
    chk("t2_g0b_dest", wb_dest, 10);
    chk("t2_g0b_data", wb_data, 32'hAA);
    @(negedge clock);
    chk("t2_g1b_dest", wb_dest, 11);
    chk("t2_g1b_data", wb_data, 32'hBB);
    @(negedge clock);
    chk("t2_done", wb_valid, 0);

    // starvation: port held by p5 writes, stall in the 9th blocked-window cycle
    do_reset();
    p5_dest = 5'd7;
    set_req(2, 1'b1, 5'd9, 32'h99);
    @(negedge clock);
    set_req(2, 1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= LIMIT; k++) begin
      chk("t3_stall_low", wb_stall, 0);
      @(negedge clock);
    end
    chk("t3_stall_high", wb_stall, 1);
    chk("t3_no_wb_yet", wb_valid, 0);
    @(negedge clock);
    chk("t3_wb_valid", wb_valid, 1);
    chk("t3_wb_dest", wb_dest, 9);
    chk("t3_wb_data", wb_data, 32'h99);
    chk("t3_stall_drop", wb_stall, 0);
    p5_dest = 5'd0;

    // dest 0 is accepted and dropped
    do_reset();
    p5_dest = 5'd7;
    set_req(0, 1'b1, 5'd0, 32'h55);
    #1;
    chk("t4_ready", req_ready[0], 1);
    repeat (3) begin
      @(negedge clock);
      #1;
      chk("t4_no_wb", wb_valid, 0);
      chk("t4_slot_empty", req_ready, 3'b111);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    p5_dest = 5'd0;
    @(negedge clock);
    chk("t4_no_wb_free", wb_valid, 0);

    // full slot back-pressures until its grant, then refills without merging
    do_reset();
    p5_dest = 5'd7;
    set_req(1, 1'b1, 5'd4, 32'h44);
    @(negedge clock);
    set_req(1, 1'b1, 5'd6, 32'h66);
    #1;
    chk("t5_ready_low", req_ready[1], 0);
    repeat (2) begin
      @(negedge clock);
      #1;
      chk("t5_ready_low", req_ready[1], 0);
    end
    p5_dest = 5'd0;
    #1;
    chk("t5_ready_grant", req_ready[1], 1);
    @(negedge clock);
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("t5_first_dest", wb_dest, 4);
    chk("t5_first_data", wb_data, 32'h44);
    @(negedge clock);
    chk("t5_second_valid", wb_valid, 1);
    chk("t5_second_dest", wb_dest, 6);
    chk("t5_second_data", wb_data, 32'h66);

    // reset with two results held discards them
    do_reset();
    p5_dest = 5'd7;
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    @(negedge clock);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    chk("t6_held", req_ready, 3'b100);
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    p5_dest = 5'd0;
    chk("t6_ready", req_ready, 3'b111);
    chk("t6_stall", wb_stall, 0);
    repeat (5) begin
      @(negedge clock);
      chk("t6_no_wb", wb_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
